// File: rtl/dmem_access_pkg.sv
// Shared types and helpers for the data-memory access unit.
package dmem_access_pkg;

    localparam int unsigned BYTE_W = 8;
    localparam int unsigned HALF_W = 16;
    localparam int unsigned WORD_W = 32;

    typedef enum logic [1:0] {
        SZ_B   = 2'b00,
        SZ_H   = 2'b01,
        SZ_W   = 2'b10,
        SZ_BAD = 2'b11
    } size_t;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        MERGE,
        STORE,
        RESP
    } state_t;

    // True when the size code is illegal or the address is not naturally aligned.
    function automatic logic req_is_bad(input size_t size, input logic [1:0] low);
        logic bad;
        case (size)
            SZ_B:    bad = 1'b0;
            SZ_H:    bad = low[0];
            SZ_W:    bad = |low;
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/dmem_lane.sv
// Byte-lane steering: extracts/extends a load lane and merges a sub-word store.
module dmem_lane
    import dmem_access_pkg::*;
(
    input  logic [WORD_W-1:0] word,
    input  logic [HALF_W-1:0] wdata,
    input  logic [1:0]        lane,
    input  size_t             size,
    input  logic              is_unsigned,
    output logic [WORD_W-1:0] load_data,
    output logic [WORD_W-1:0] merged
);

    logic [4:0]        sh;
    logic [WORD_W-1:0] shifted;
    logic [WORD_W-1:0] mask;
    logic [WORD_W-1:0] ins;

    // Load path: shift the addressed lane down to bit 0, then zero/sign extend.
    always_comb begin
        sh      = {lane, 3'b000};
        shifted = word >> sh;
        case (size)
            SZ_B: load_data = is_unsigned
                ? {{(WORD_W-BYTE_W){1'b0}}, shifted[BYTE_W-1:0]}
                : {{(WORD_W-BYTE_W){shifted[BYTE_W-1]}}, shifted[BYTE_W-1:0]};
            SZ_H: load_data = is_unsigned
                ? {{(WORD_W-HALF_W){1'b0}}, shifted[HALF_W-1:0]}
                : {{(WORD_W-HALF_W){shifted[HALF_W-1]}}, shifted[HALF_W-1:0]};
            default: load_data = word;
        endcase
    end

    // Store path: replace only the addressed byte/half of the word read back.
    always_comb begin
        mask = '0;
        ins  = '0;
        case (size)
            SZ_B: begin
                mask = {{(WORD_W-BYTE_W){1'b0}}, {BYTE_W{1'b1}}} << sh;
                ins  = {{(WORD_W-BYTE_W){1'b0}}, wdata[BYTE_W-1:0]} << sh;
            end
            SZ_H: begin
                mask = {{(WORD_W-HALF_W){1'b0}}, {HALF_W{1'b1}}} << sh;
                ins  = {{(WORD_W-HALF_W){1'b0}}, wdata} << sh;
            end
            default: begin
                mask = '0;
                ins  = '0;
            end
        endcase
        merged = (word & ~mask) | (ins & mask);
    end

endmodule

// File: rtl/dmem_access_unit.sv
// Request-side master for dmem: byte/half/word loads and stores with
// read-modify-write for sub-word stores, one request in flight.
module dmem_access_unit
    import dmem_access_pkg::*;
#(
    parameter int unsigned n = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         req_valid,
    output logic         req_ready,
    input  logic         req_write,
    input  logic [1:0]   req_size,
    input  logic         req_unsigned,
    input  logic [n-1:0] req_addr,
    input  logic [n-1:0] req_wdata,
    output logic         rsp_valid,
    input  logic         rsp_ready,
    output logic [n-1:0] rsp_rdata,
    output logic         rsp_err,
    output logic         mem_write_enable,
    output logic [n-1:0] mem_addr,
    output logic [n-1:0] mem_writedata,
    input  logic [n-1:0] mem_readdata
);

    state_t            state;
    size_t             r_size;
    logic              r_unsigned;
    logic [1:0]        r_lane;
    logic [HALF_W-1:0] r_wdata;

    logic [n-1:0]      load_data;
    logic [n-1:0]      merged;
    size_t             in_size;

    assign in_size = size_t'(req_size);

    dmem_lane u_lane (
        .word        (mem_readdata),
        .wdata       (r_wdata),
        .lane        (r_lane),
        .size        (r_size),
        .is_unsigned (r_unsigned),
        .load_data   (load_data),
        .merged      (merged)
    );

    // Request FSM; all handshake and dmem-side outputs are registered here.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state            <= IDLE;
            req_ready        <= 1'b1;
            rsp_valid        <= 1'b0;
            rsp_err          <= 1'b0;
            rsp_rdata        <= '0;
            mem_write_enable <= 1'b0;
            mem_addr         <= '0;
            mem_writedata    <= '0;
            r_size           <= SZ_B;
            r_unsigned       <= 1'b0;
            r_lane           <= '0;
            r_wdata          <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid && req_ready) begin
                        req_ready  <= 1'b0;
                        r_size     <= in_size;
                        r_unsigned <= req_unsigned;
                        r_lane     <= req_addr[1:0];
                        r_wdata    <= req_wdata[HALF_W-1:0];
                        if (req_is_bad(in_size, req_addr[1:0])) begin
                            // Bad request: respond directly, dmem untouched.
                            rsp_err   <= 1'b1;
                            rsp_rdata <= '0;
                            rsp_valid <= 1'b1;
                            state     <= RESP;
                        end else begin
                            mem_addr <= {2'b00, req_addr[n-1:2]};
                            if (!req_write) begin
                                state <= LOAD;
                            end else if (in_size == SZ_W) begin
                                mem_writedata    <= req_wdata;
                                mem_write_enable <= 1'b1;
                                state            <= STORE;
                            end else begin
                                state <= MERGE;
                            end
                        end
                    end
                end
                LOAD: begin
                    rsp_rdata <= load_data;
                    rsp_err   <= 1'b0;
                    rsp_valid <= 1'b1;
                    state     <= RESP;
                end
                MERGE: begin
                    mem_writedata    <= merged;
                    mem_write_enable <= 1'b1;
                    state            <= STORE;
                end
                STORE: begin
                    mem_write_enable <= 1'b0;
                    rsp_rdata        <= '0;
                    rsp_err          <= 1'b0;
                    rsp_valid        <= 1'b1;
                    state            <= RESP;
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        rsp_err   <= 1'b0;
                        rsp_rdata <= '0;
                        req_ready <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state     <= IDLE;
                    req_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_access_unit.sv
// Self-checking bench for dmem_access_unit with a behavioural dmem and a
// byte-array reference model.
module tb_dmem_access_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_write = 1'b0;
    logic [1:0]  req_size = 2'b00;
    logic        req_unsigned = 1'b0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        mem_write_enable;
    logic [31:0] mem_addr;
    logic [31:0] mem_writedata;
    logic [31:0] mem_readdata;

    int checks = 0;
    int errors = 0;
    int we_cnt = 0;
    int acc_cnt = 0;

    logic [31:0] dmem [0:63] = '{default: '0};
    logic [7:0]  ref_mem [0:255] = '{default: '0};

    always #5 clk = ~clk;

    dmem_access_unit #(.n(32)) dut (
        .clk              (clk),
        .reset            (reset),
        .req_valid        (req_valid),
        .req_ready        (req_ready),
        .req_write        (req_write),
        .req_size         (req_size),
        .req_unsigned     (req_unsigned),
        .req_addr         (req_addr),
        .req_wdata        (req_wdata),
        .rsp_valid        (rsp_valid),
        .rsp_ready        (rsp_ready),
        .rsp_rdata        (rsp_rdata),
        .rsp_err          (rsp_err),
        .mem_write_enable (mem_write_enable),
        .mem_addr         (mem_addr),
        .mem_writedata    (mem_writedata),
        .mem_readdata     (mem_readdata)
    );

    assign mem_readdata = dmem[mem_addr[5:0]];

    always @(posedge clk) begin
        if (mem_write_enable) dmem[mem_addr[5:0]] <= mem_writedata;
        if (mem_write_enable) we_cnt <= we_cnt + 1;
        if (req_valid && req_ready && !reset) acc_cnt <= acc_cnt + 1;
    end

    // ---------------- reference model ----------------
    function automatic logic m_err(input logic [1:0] sz, input logic [31:0] a);
        return (sz == 2'd3) || (sz == 2'd1 && a[0]) || (sz == 2'd2 && a[1:0] != 2'd0);
    endfunction

    function automatic logic [31:0] m_load(input logic [1:0] sz, input logic uns, input logic [31:0] a);
        int nb;
        logic [31:0] v;
        nb = 1 << sz;
        v = '0;
        for (int i = 0; i < nb; i++) v = v | (32'(ref_mem[int'(a) + i]) << (8 * i));
        if (!uns && nb < 4 && v[8 * nb - 1]) v = v | (32'hFFFF_FFFF << (8 * nb));
        return v;
    endfunction

    task automatic m_store(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] d);
        int nb;
        nb = 1 << sz;
        for (int i = 0; i < nb; i++) ref_mem[int'(a) + i] = 8'(d >> (8 * i));
    endtask

    function automatic logic [31:0] m_word(input int idx);
        return {ref_mem[4*idx+3], ref_mem[4*idx+2], ref_mem[4*idx+1], ref_mem[4*idx]};
    endfunction

    function automatic int m_lat(input logic w, input logic [1:0] sz, input logic [31:0] a);
        if (m_err(sz, a)) return 1;
        if (!w || sz == 2'd2) return 2;
        return 3;
    endfunction

    // Drive one request, wait for its response and acknowledge it.
    task automatic do_req(input logic w, input logic [1:0] sz, input logic uns,
                          input logic [31:0] a, input logic [31:0] wd,
                          output logic [31:0] rd, output logic er,
                          output int lat, output int wes);
        int n;
        int start_we;
        @(negedge clk);
        req_write = w; req_size = sz; req_unsigned = uns; req_addr = a; req_wdata = wd;
        req_valid = 1'b1;
        n = 0;
        while (!req_ready && n < 50) begin @(negedge clk); n++; end
        start_we = we_cnt;
        @(negedge clk);
        req_valid = 1'b0;
        lat = 1;
        while (!rsp_valid && lat < 50) begin @(negedge clk); lat++; end
        rd = rsp_rdata;
        er = rsp_err;
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        wes = we_cnt - start_we;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset;
        #12;
        checks++;
        if ({rsp_valid, rsp_err, mem_write_enable} !== 3'b000) begin
            errors++; $display("FAIL reset_flags got=%b exp=000", {rsp_valid, rsp_err, mem_write_enable});
        end
        checks++;
        if ({rsp_rdata, mem_addr, mem_writedata} !== 96'd0) begin
            errors++; $display("FAIL reset_data got=%h/%h/%h exp=0", rsp_rdata, mem_addr, mem_writedata);
        end
        @(negedge clk); reset = 1'b0;
        @(negedge clk);
        checks++;
        if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got=%b exp=1", req_ready); end
    endtask

    task automatic test_word_store_load;
        logic [31:0] rd; logic er; int lat; int wes;
        do_req(1'b1, 2'd2, 1'b0, 32'h0, 32'hFFFF_FFFF, rd, er, lat, wes);
        m_store(2'd2, 32'h0, 32'hFFFF_FFFF);
        checks++;
        if (er !== 1'b0 || rd !== 32'h0) begin errors++; $display("FAIL wst_rsp got=%b/%h exp=0/0", er, rd); end
        checks++;
        if (lat != 2) begin errors++; $display("FAIL wst_lat got=%0d exp=2", lat); end
        checks++;
        if (wes != 1) begin errors++; $display("FAIL wst_we_cycles got=%0d exp=1", wes); end
        do_req(1'b0, 2'd2, 1'b0, 32'h0, 32'h0, rd, er, lat, wes);
        checks++;
        if (rd !== 32'hFFFF_FFFF || er !== 1'b0) begin errors++; $display("FAIL wld_data got=%h/%b exp=ffffffff/0", rd, er); end
        checks++;
        if (lat != 2 || wes != 0) begin errors++; $display("FAIL wld_lat got=%0d/%0d exp=2/0", lat, wes); end
    endtask

    task automatic test_byte_store;
        logic [31:0] rd; logic er; int lat; int wes;
        do_req(1'b1, 2'd2, 1'b0, 32'h4, 32'h0000_FFFF, rd, er, lat, wes);
        m_store(2'd2, 32'h4, 32'h0000_FFFF);
        do_req(1'b1, 2'd0, 1'b0, 32'h6, 32'h1234_56AB, rd, er, lat, wes);
        m_store(2'd0, 32'h6, 32'h1234_56AB);
        checks++;
        if (lat != 3 || wes != 1) begin errors++; $display("FAIL bst_lat got=%0d/%0d exp=3/1", lat, wes); end
        checks++;
        if (dmem[1] !== 32'h00AB_FFFF) begin errors++; $display("FAIL bst_word got=%h exp=00abffff", dmem[1]); end
        do_req(1'b0, 2'd0, 1'b0, 32'h6, 32'h0, rd, er, lat, wes);
        checks++;
        if (rd !== 32'hFFFF_FFAB) begin errors++; $display("FAIL bld_signed got=%h exp=ffffffab", rd); end
        do_req(1'b0, 2'd0, 1'b1, 32'h6, 32'h0, rd, er, lat, wes);
        checks++;
        if (rd !== 32'h0000_00AB) begin errors++; $display("FAIL bld_unsigned got=%h exp=000000ab", rd); end
    endtask

    task automatic test_half_load;
        logic [31:0] rd; logic er; int lat; int wes;
        do_req(1'b1, 2'd2, 1'b0, 32'h4, 32'h0000_FFFF, rd, er, lat, wes);
        m_store(2'd2, 32'h4, 32'h0000_FFFF);
        do_req(1'b0, 2'd1, 1'b0, 32'h4, 32'h0, rd, er, lat, wes);
        checks++;
        if (rd !== 32'hFFFF_FFFF) begin errors++; $display("FAIL hld_lo got=%h exp=ffffffff", rd); end
        do_req(1'b0, 2'd1, 1'b0, 32'h6, 32'h0, rd, er, lat, wes);
        checks++;
        if (rd !== 32'h0000_0000) begin errors++; $display("FAIL hld_hi got=%h exp=00000000", rd); end
    endtask

    task automatic test_errors;
        logic [31:0] rd; logic er; int lat; int wes;
        logic [1:0]  szs [3];
        logic [31:0] adrs [3];
        szs  = '{2'd1, 2'd2, 2'd3};
        adrs = '{32'h5, 32'h2, 32'h4};
        for (int i = 0; i < 3; i++) begin
            do_req(1'b1, szs[i], 1'b0, adrs[i], 32'hDEAD_BEEF, rd, er, lat, wes);
            checks++;
            if (er !== 1'b1 || rd !== 32'h0 || lat != 1 || wes != 0) begin
                errors++;
                $display("FAIL err_case%0d got err=%b rd=%h lat=%0d we=%0d exp 1/0/1/0", i, er, rd, lat, wes);
            end
        end
        checks++;
        if (dmem[1] !== m_word(1) || dmem[0] !== m_word(0)) begin
            errors++; $display("FAIL err_mem got=%h/%h exp=%h/%h", dmem[0], dmem[1], m_word(0), m_word(1));
        end
    endtask

    task automatic test_hold_resp;
        logic [31:0] snap;
        int n;
        @(negedge clk);
        req_write = 1'b0; req_size = 2'd2; req_unsigned = 1'b0; req_addr = 32'h4; req_valid = 1'b1;
        n = 0;
        while (!req_ready && n < 50) begin @(negedge clk); n++; end
        @(negedge clk);
        req_valid = 1'b0;
        n = 0;
        while (!rsp_valid && n < 50) begin @(negedge clk); n++; end
        snap = rsp_rdata;
        checks++;
        if (snap !== m_word(1)) begin errors++; $display("FAIL hold_data got=%h exp=%h", snap, m_word(1)); end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if (rsp_valid !== 1'b1 || rsp_rdata !== snap || req_ready !== 1'b0) begin
                errors++;
                $display("FAIL hold_stable%0d got v=%b d=%h rdy=%b exp 1/%h/0", i, rsp_valid, rsp_rdata, req_ready, snap);
            end
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        checks++;
        if (rsp_valid !== 1'b0) begin errors++; $display("FAIL hold_release got=%b exp=0", rsp_valid); end
    endtask

    task automatic test_back_to_back;
        logic [31:0] rdat [2];
        logic [31:0] exp0, exp1;
        int got, n, acc0;
        logic drop;
        exp0 = m_load(2'd2, 1'b0, 32'h0);
        exp1 = m_load(2'd1, 1'b1, 32'h6);
        rsp_ready = 1'b1;
        @(negedge clk);
        acc0 = acc_cnt;
        req_write = 1'b0; req_size = 2'd2; req_unsigned = 1'b0; req_addr = 32'h0; req_valid = 1'b1;
        n = 0;
        while (!req_ready && n < 50) begin @(negedge clk); n++; end
        @(negedge clk);
        req_size = 2'd1; req_unsigned = 1'b1; req_addr = 32'h6;
        got = 0; n = 0; drop = 1'b0;
        while (got < 2 && n < 40) begin
            @(negedge clk); n++;
            if (drop) begin req_valid = 1'b0; drop = 1'b0; end
            if (rsp_valid) begin rdat[got] = rsp_rdata; got++; end
            if (req_valid && req_ready) drop = 1'b1;
        end
        req_valid = 1'b0;
        rsp_ready = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (got != 2 || rdat[0] !== exp0 || rdat[1] !== exp1) begin
            errors++; $display("FAIL b2b_data got=%0d %h %h exp=2 %h %h", got, rdat[0], rdat[1], exp0, exp1);
        end
        checks++;
        if (acc_cnt - acc0 != 2) begin errors++; $display("FAIL b2b_accepts got=%0d exp=2", acc_cnt - acc0); end
    endtask

    task automatic test_reset_mid_merge;
        logic [31:0] rd; logic er; int lat; int wes; int n; int we0;
        logic seen;
        @(negedge clk);
        req_write = 1'b1; req_size = 2'd0; req_unsigned = 1'b0; req_addr = 32'h9; req_wdata = 32'h5A;
        req_valid = 1'b1;
        n = 0;
        while (!req_ready && n < 50) begin @(negedge clk); n++; end
        @(negedge clk);
        req_valid = 1'b0;
        we0 = we_cnt;
        #1 reset = 1'b1;
        #1;
        checks++;
        if ({rsp_valid, rsp_err, mem_write_enable} !== 3'b000 || {rsp_rdata, mem_addr, mem_writedata} !== 96'd0) begin
            errors++;
            $display("FAIL rst_mid_outputs got v=%b e=%b we=%b d=%h a=%h wd=%h exp all 0",
                     rsp_valid, rsp_err, mem_write_enable, rsp_rdata, mem_addr, mem_writedata);
        end
        repeat (2) @(negedge clk);
        reset = 1'b0;
        seen = 1'b0;
        repeat (4) begin @(negedge clk); if (rsp_valid) seen = 1'b1; end
        checks++;
        if (seen !== 1'b0 || we_cnt != we0) begin
            errors++; $display("FAIL rst_mid_no_rsp got rsp=%b writes=%0d exp 0/0", seen, we_cnt - we0);
        end
        checks++;
        if (dmem[2] !== m_word(2)) begin errors++; $display("FAIL rst_mid_mem got=%h exp=%h", dmem[2], m_word(2)); end
        do_req(1'b1, 2'd0, 1'b0, 32'h9, 32'hC3, rd, er, lat, wes);
        m_store(2'd0, 32'h9, 32'hC3);
        do_req(1'b0, 2'd0, 1'b1, 32'h9, 32'h0, rd, er, lat, wes);
        checks++;
        if (rd !== 32'h0000_00C3 || er !== 1'b0 || lat != 2) begin
            errors++; $display("FAIL rst_mid_after got=%h/%b/%0d exp=000000c3/0/2", rd, er, lat);
        end
    endtask

    task automatic test_random;
        logic [31:0] rd; logic er; int lat; int wes;
        logic w, uns; logic [1:0] sz; logic [31:0] a, wd;
        logic [31:0] exp_rd; logic exp_er;
        for (int i = 0; i < 150; i++) begin
            w   = 1'($urandom_range(0, 1));
            sz  = 2'($urandom_range(0, 3));
            uns = 1'($urandom_range(0, 1));
            a   = 32'($urandom_range(0, 255));
            wd  = $urandom;
            exp_er = m_err(sz, a);
            exp_rd = (!exp_er && !w) ? m_load(sz, uns, a) : 32'h0;
            do_req(w, sz, uns, a, wd, rd, er, lat, wes);
            if (!exp_er && w) m_store(sz, a, wd);
            checks++;
            if (rd !== exp_rd || er !== exp_er) begin
                errors++; $display("FAIL rnd%0d_rsp w=%b sz=%0d a=%h got=%h/%b exp=%h/%b", i, w, sz, a, rd, er, exp_rd, exp_er);
            end
            checks++;
            if (lat != m_lat(w, sz, a) || wes != ((!exp_er && w) ? 1 : 0)) begin
                errors++; $display("FAIL rnd%0d_timing got lat=%0d we=%0d exp lat=%0d", i, lat, wes, m_lat(w, sz, a));
            end
        end
        for (int j = 0; j < 64; j++) begin
            checks++;
            if (dmem[j] !== m_word(j)) begin errors++; $display("FAIL rnd_mem%0d got=%h exp=%h", j, dmem[j], m_word(j)); end
        end
    endtask

    initial begin
        test_reset();
        test_word_store_load();
        test_byte_store();
        test_half_load();
        test_errors();
        test_hold_resp();
        test_back_to_back();
        test_reset_mid_merge();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
